instruction_decoder: RTL and testbench
======================================

// Module: instruction_decoder
// PURPOSE
//  Upstream of the light display core. Parses the ASCII puzzle text one byte
//  per handshake, e.g. "turn on 0,0 through 999,999\n".
//  Emits one packed command per valid line on a valid/ready/last stream.
//  instr_last is asserted on the final command of the input.
// PARAMETERS
//  POSITION_BITS      12  width of each coordinate field
//  INSTRUCTION_WIDTH  50  2+4*POSITION_BITS; output word width
//  COUNT_WIDTH        16  width of cmd_count
// PORTS
//  clk          in   1     clock
//  reset        in   1     synchronous, active-high
//  in_valid     in   1     input byte valid
//  in_ready     out  1     input byte accepted when in_valid&&in_ready
//  in_data      in   8     ASCII byte
//  in_last      in   1     marks final byte of the input stream
//  instr_valid  out  1     command valid
//  instr_ready  in   1     downstream accepts command
//  instr_last   out  1     final command of stream
//  instr_data   out  IW    {op[1:0],start_row,start_col,end_row,end_col}
//  cmd_count    out  CW    number of commands emitted (accepted downstream)
//  parse_error  out  1     sticky; malformed line seen
//  done         out  1     sticky; all commands delivered incl. last
// BEHAVIOUR
//  Reset: in_ready=0, instr_valid=0, instr_last=0, instr_data=0,
//   cmd_count=0, parse_error=0, done=0. Parser and holding registers are cleared.
//   A reset mid-line or mid-handshake drops all pending commands.
//   in_ready rises the cycle after reset falls.
//  Op decode (letters seen before the first digit of a line):
//   any 'g' -> TOGGLE 2'b01; else any 'f' -> TURN_OFF 2'b00;
//   else TURN_ON 2'b11. Letters after the first digit are ignored.
//  Numbers: a digit run accumulates acc = acc*10 + digit, truncated mod
//   2**POSITION_BITS. The first non-digit after a run closes the field.
//   Fields 0..3 map to start_row, start_col, end_row, end_col.
//   '\r', ',' and ' ' are plain separators.
//  Line end is '\n', or the in_last byte if that byte is not '\n'.
//  At line end:
//   - exactly 4 fields: command complete.
//   - 1-3 fields, or a 5th field started: line discarded, parse_error<=1.
//   - 0 chars or only whitespace: ignored silently, no error.
//  One-deep holding register (held_valid), so instr_last is known before
//   any command is presented:
//   - complete with held empty: new command -> held; no output.
//   - complete with held full: held -> output reg (instr_last=0) and
//     new -> held, in the same cycle.
//  in_ready = 0 whenever instr_valid=1, or in FLUSH/DONE.
//   The input stalls until the output handshake completes.
//  FSM:
//   PARSE: accepts bytes. Byte with in_last (after line-end processing) -> FLUSH.
//   FLUSH: once the output reg is empty:
//    - held full: held -> output with instr_last=1, then DONE.
//    - held empty: parse_error<=1, done<=1, DONE with no output.
//   DONE: in_ready=0. done=1 once the last command handshake completes.
//    Stays here until reset.
//  instr_data/instr_last stay stable while instr_valid && !instr_ready.
//  cmd_count increments on each instr_valid && instr_ready. It saturates.
//  Latency: a command is presented 1 cycle after the terminating byte of
//   the following valid line is accepted, or 1 cycle after FLUSH entry.
// TESTING
//  "turn on 0,0 through 999,999\n" with in_last on '\n'
//   -> one word {11,0,0,999,999}, instr_last=1, cmd_count=1, done=1.
//  Three lines (toggle 0,0-999,0 / turn off 499,499-500,500 / turn on 1,2-3,4)
//   -> ops 01,00,11 in order; instr_last only on the third; parse_error=0.
//  instr_ready low 20 cycles on the first command
//   -> instr_data stable, in_ready=0 throughout, no byte lost, order kept.
//  Last line followed by "\n\n" with in_last on the final '\n'
//   -> last command flagged instr_last=1; no extra word.
//  Line "turn on 1,2 through 3\n" between valid lines
//   -> discarded, parse_error=1, the neighbouring commands are unaffected.
//  "toggle 4097,1 through 2,3" with in_last on '3' and no newline
//   -> {01,1,1,2,3} with instr_last=1. Reset asserted mid-line then replay
//   -> no stale output.

Source files
------------

// File: rtl/instruction_decoder.sv
// instruction_decoder
//   Parses ASCII puzzle lines such as "turn on 0,0 through 999,999\n", one
//   byte per handshake, and emits one packed command per valid line on a
//   valid/ready/last stream. A one-deep holding register delays every command
//   until the following line (or end of input) is known, so instr_last can be
//   set on the final word when it is presented.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | first cycle after reset; input not yet accepted
//   PARSE  | accepting bytes, building fields of the current line
//   FLUSH  | input finished; waiting for the output reg to drain
//   DONE   | final command presented (or none); waits for reset
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   byte stream handshake; in_data byte, in_last marks end
//   instr_valid/ready   command stream handshake; instr_last on final word
//   instr_data          {op[1:0], start_row, start_col, end_row, end_col}
//   cmd_count           saturating count of accepted commands
//   parse_error         sticky: malformed line or empty input
//   done                sticky: final command delivered
module instruction_decoder #(
  parameter int POSITION_BITS     = 12,
  parameter int INSTRUCTION_WIDTH = 2 + 4 * POSITION_BITS,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  output logic                         instr_valid,
  input  logic                         instr_ready,
  output logic                         instr_last,
  output logic [INSTRUCTION_WIDTH-1:0] instr_data,
  output logic [COUNT_WIDTH-1:0]       cmd_count,
  output logic                         parse_error,
  output logic                         done
);

  localparam int PB = POSITION_BITS;

  typedef enum logic [1:0] {S_IDLE, S_PARSE, S_FLUSH, S_DONE} state_t;

  state_t                         state;
  logic [PB-1:0]                  acc;
  logic [PB-1:0]                  fld [4];
  logic [2:0]                     cnt;      // fields started this line, saturates at 5
  logic                           in_digit;
  logic                           op_g;
  logic                           op_f;
  logic                           nonws;
  logic                           held_valid;
  logic [INSTRUCTION_WIDTH-1:0]   held_data;

  logic                           accept;
  logic                           is_digit;
  logic                           is_ws;
  logic                           line_end;
  logic [PB-1:0]                  acc_n;
  logic [2:0]                     cnt_n;
  logic [PB-1:0]                  fld_n [4];
  logic                           g_n;
  logic                           f_n;
  logic                           nonws_n;
  logic [1:0]                     op_n;
  logic [INSTRUCTION_WIDTH-1:0]   cmd_n;
  logic                           complete;
  logic                           bad;

  assign in_ready = (state == S_PARSE) && !instr_valid;
  assign accept   = in_valid && in_ready;

  // Next parser state including the byte currently offered, so that a line
  // terminated by an in_last digit still counts that digit.
  always_comb begin
    is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    is_ws    = (in_data == 8'h20) || (in_data == 8'h0d) ||
               (in_data == 8'h09) || (in_data == 8'h0a);
    line_end = (in_data == 8'h0a) || in_last;
    acc_n    = acc;
    cnt_n    = cnt;
    g_n      = op_g;
    f_n      = op_f;
    nonws_n  = nonws || !is_ws;
    for (int i = 0; i < 4; i++) fld_n[i] = fld[i];

    if (is_digit) begin
      if (in_digit) begin
        acc_n = (acc << 3) + (acc << 1) + {{(PB-4){1'b0}}, in_data[3:0]};
      end else begin
        acc_n = {{(PB-4){1'b0}}, in_data[3:0]};
        if (cnt < 3'd5) cnt_n = cnt + 3'd1;
      end
      // The open field is kept current so no separate close step is needed.
      if (cnt_n >= 3'd1 && cnt_n <= 3'd4) fld_n[cnt_n[1:0] - 2'd1] = acc_n;
    end else if (cnt == 3'd0) begin
      if (in_data == 8'h67) g_n = 1'b1;
      if (in_data == 8'h66) f_n = 1'b1;
    end

    op_n     = g_n ? 2'b01 : (f_n ? 2'b00 : 2'b11);
    cmd_n    = {op_n, fld_n[0], fld_n[1], fld_n[2], fld_n[3]};
    complete = line_end && (cnt_n == 3'd4);
    bad      = line_end && !complete && ((cnt_n != 3'd0) || nonws_n);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      in_digit    <= 1'b0;
      op_g        <= 1'b0;
      op_f        <= 1'b0;
      nonws       <= 1'b0;
      for (int i = 0; i < 4; i++) fld[i] <= '0;
      held_valid  <= 1'b0;
      held_data   <= '0;
      instr_valid <= 1'b0;
      instr_last  <= 1'b0;
      instr_data  <= '0;
      cmd_count   <= '0;
      parse_error <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (instr_valid && instr_ready) begin
        instr_valid <= 1'b0;
        if (cmd_count != {COUNT_WIDTH{1'b1}}) cmd_count <= cmd_count + 1'b1;
        if (instr_last) done <= 1'b1;
      end

      case (state)
        S_IDLE: state <= S_PARSE;

        S_PARSE: begin
          if (accept) begin
            if (line_end) begin
              acc      <= '0;
              cnt      <= '0;
              in_digit <= 1'b0;
              op_g     <= 1'b0;
              op_f     <= 1'b0;
              nonws    <= 1'b0;
              for (int i = 0; i < 4; i++) fld[i] <= '0;
            end else begin
              acc      <= acc_n;
              cnt      <= cnt_n;
              in_digit <= is_digit;
              op_g     <= g_n;
              op_f     <= f_n;
              nonws    <= nonws_n;
              for (int i = 0; i < 4; i++) fld[i] <= fld_n[i];
            end
            // in_ready implies the output reg is empty, so held can always move out.
            if (complete) begin
              if (held_valid) begin
                instr_valid <= 1'b1;
                instr_data  <= held_data;
                instr_last  <= 1'b0;
              end
              held_data  <= cmd_n;
              held_valid <= 1'b1;
            end
            if (bad) parse_error <= 1'b1;
            if (in_last) state <= S_FLUSH;
          end
        end

        S_FLUSH: begin
          if (!instr_valid) begin
            if (held_valid) begin
              instr_valid <= 1'b1;
              instr_data  <= held_data;
              instr_last  <= 1'b1;
              held_valid  <= 1'b0;
            end else begin
              parse_error <= 1'b1;
              done        <= 1'b1;
            end
            state <= S_DONE;
          end
        end

        default: state <= S_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_decoder.sv
module tb_instruction_decoder;
  localparam int PB = 12;
  localparam int IW = 2 + 4 * PB;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          instr_valid;
  logic          instr_ready;
  logic          instr_last;
  logic [IW-1:0] instr_data;
  logic [CW-1:0] cmd_count;
  logic          parse_error;
  logic          done;

  int checks   = 0;
  int failures = 0;

  logic [IW-1:0] got_data [$];
  logic          got_last [$];

  instruction_decoder #(.POSITION_BITS(PB), .INSTRUCTION_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_last(instr_last),
    .instr_data(instr_data), .cmd_count(cmd_count),
    .parse_error(parse_error), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && instr_valid && instr_ready) begin
      got_data.push_back(instr_data);
      got_last.push_back(instr_last);
    end
  end

  function automatic logic [IW-1:0] mk(input logic [1:0] op, input int a, input int b,
                                       input int c, input int d);
    return {op, PB'(a), PB'(b), PB'(c), PB'(d)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    got_data.delete();
    got_last.delete();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = b; in_last = last;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%0b required 1 for byte %h", in_ready, b);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_str(input string s, input logic last_on_final);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], last_on_final && (i == s.len() - 1));
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 500) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL done_timeout: done=%0b required 1", done);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic check_words(input string name, input logic [IW-1:0] exp_d [$],
                             input logic exp_l [$]);
    checks++;
    if (got_data.size() !== exp_d.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d words required %0d", name, got_data.size(), exp_d.size());
    end
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < got_data.size()) begin
        checks++;
        if (got_data[i] !== exp_d[i] || got_last[i] !== exp_l[i]) begin
          failures++;
          $display("FAIL %s_word%0d: got %h last=%0b required %h last=%0b",
                   name, i, got_data[i], got_last[i], exp_d[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, instr_valid, instr_last, parse_error, done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 00000",
               {in_ready, instr_valid, instr_last, parse_error, done});
    end
    checks++;
    if (instr_data !== '0 || cmd_count !== '0) begin
      failures++;
      $display("FAIL reset_data: got data=%h count=%0d required 0 0", instr_data, cmd_count);
    end
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_early: got %0b required 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_single();
    logic [IW-1:0] ed [$];
    logic el [$];
    do_reset();
    send_str("turn on 0,0 through 999,999\n", 1'b1);
    wait_done();
    ed = '{mk(2'b11, 0, 0, 999, 999)}; el = '{1'b1};
    check_words("single", ed, el);
    checks++;
    if (cmd_count !== 16'd1 || parse_error !== 1'b0) begin
      failures++;
      $display("FAIL single_status: got count=%0d err=%0b required 1 0", cmd_count, parse_error);
    end
  endtask

  task automatic test_three_lines();
    logic [IW-1:0] ed [$];
    logic el [$];
    do_reset();
    send_str("toggle 0,0 through 999,0\n", 1'b0);
    send_str("turn off 499,499 through 500,500\n", 1'b0);
    send_str("turn on 1,2 through 3,4\n", 1'b1);
    wait_done();
    ed = '{mk(2'b01, 0, 0, 999, 0), mk(2'b00, 499, 499, 500, 500), mk(2'b11, 1, 2, 3, 4)};
    el = '{1'b0, 1'b0, 1'b1};
    check_words("three", ed, el);
    checks++;
    if (cmd_count !== 16'd3 || parse_error !== 1'b0) begin
      failures++;
      $display("FAIL three_status: got count=%0d err=%0b required 3 0", cmd_count, parse_error);
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [IW-1:0] ed [$];
    logic el [$];
    do_reset();
    instr_ready = 1'b0;
    send_str("toggle 0,0 through 999,0\n", 1'b0);
    send_str("turn off 499,499 through 500,500\n", 1'b0);
    fork
      send_str("turn on 1,2 through 3,4\n", 1'b1);
      begin
        int t = 0;
        while (!instr_valid && t < 20) begin
          @(negedge clk);
          t++;
        end
        repeat (20) begin
          @(negedge clk);
          checks++;
          if (instr_valid !== 1'b1 || in_ready !== 1'b0 ||
              instr_data !== mk(2'b01, 0, 0, 999, 0)) begin
            failures++;
            $display("FAIL stall_hold: got valid=%0b in_ready=%0b data=%h required 1 0 %h",
                     instr_valid, in_ready, instr_data, mk(2'b01, 0, 0, 999, 0));
          end
        end
        instr_ready = 1'b1;
      end
    join
    wait_done();
    ed = '{mk(2'b01, 0, 0, 999, 0), mk(2'b00, 499, 499, 500, 500), mk(2'b11, 1, 2, 3, 4)};
    el = '{1'b0, 1'b0, 1'b1};
    check_words("stall", ed, el);
  endtask

  task automatic test_trailing_newlines();
    logic [IW-1:0] ed [$];
    logic el [$];
    do_reset();
    send_str("toggle 1,1 through 2,2\n", 1'b0);
    send_str("turn off 3,3 through 4,4\n\n\n", 1'b1);
    wait_done();
    ed = '{mk(2'b01, 1, 1, 2, 2), mk(2'b00, 3, 3, 4, 4)}; el = '{1'b0, 1'b1};
    check_words("trail", ed, el);
    checks++;
    if (parse_error !== 1'b0 || cmd_count !== 16'd2) begin
      failures++;
      $display("FAIL trail_status: got err=%0b count=%0d required 0 2", parse_error, cmd_count);
    end
  endtask

  task automatic test_error_line();
    logic [IW-1:0] ed [$];
    logic el [$];
    do_reset();
    send_str("turn on 5,6 through 7,8\n", 1'b0);
    send_str("turn on 1,2 through 3\n", 1'b0);
    send_str("turn off 9,10 through 11,12\n", 1'b1);
    wait_done();
    ed = '{mk(2'b11, 5, 6, 7, 8), mk(2'b00, 9, 10, 11, 12)}; el = '{1'b0, 1'b1};
    check_words("err", ed, el);
    checks++;
    if (parse_error !== 1'b1 || cmd_count !== 16'd2) begin
      failures++;
      $display("FAIL err_status: got err=%0b count=%0d required 1 2", parse_error, cmd_count);
    end
  endtask

  task automatic test_empty_input();
    do_reset();
    send_str("\n", 1'b1);
    wait_done();
    checks++;
    if (parse_error !== 1'b1 || got_data.size() !== 0 || cmd_count !== 16'd0) begin
      failures++;
      $display("FAIL empty_status: got err=%0b words=%0d count=%0d required 1 0 0",
               parse_error, got_data.size(), cmd_count);
    end
  endtask

  task automatic test_no_newline_and_reset();
    logic [IW-1:0] ed [$];
    logic el [$];
    ed = '{mk(2'b01, 1, 1, 2, 3)}; el = '{1'b1};
    do_reset();
    send_str("toggle 4097,1 through 2,3", 1'b1);
    wait_done();
    check_words("nonl", ed, el);
    do_reset();
    send_str("turn on 7,7 through 8,8\nturn on 9,", 1'b0);
    do_reset();
    send_str("toggle 4097,1 through 2,3", 1'b1);
    wait_done();
    check_words("replay", ed, el);
    checks++;
    if (cmd_count !== 16'd1 || parse_error !== 1'b0) begin
      failures++;
      $display("FAIL replay_status: got count=%0d err=%0b required 1 0", cmd_count, parse_error);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; instr_ready = 1'b1;
    test_reset();
    test_single();
    test_three_lines();
    test_back_to_back_stall();
    test_trailing_newlines();
    test_error_line();
    test_empty_input();
    test_no_newline_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
